piton_aws_eth_init_seq: RTL
===========================

Name: piton_aws_eth_init_seq

Overview:
- AXI4-Lite master that brings up the Ethernet Lite MAC after reset or on host request.
- Sequence: program the station MAC address, poll for completion, then optionally enable RX and global interrupts.
- Sits between the AWS shell control logic and the register slice in front of the MAC's AXI-Lite slave. A mux selects it ahead of host OCL traffic while busy=1.

Parameters:
- POLL_MAX, 1024: maximum number of status reads before a timeout error is declared (must be ≥1).
- ENABLE_IRQ, 1: when 1, the RX-control and GIE writes are issued after programming.

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; starts the sequence when idle
- mac_addr  in  48  station address; [47:40] is the first octet on the wire; sampled on accepted start
- busy  out  1  sequence in progress
- done  out  1  sequence completed without error
- error  out  1  error response or poll timeout
- m_awvalid / m_awready  out / in  1  write address handshake
- m_awaddr  out  13  write address
- m_wvalid / m_wready  out / in  1  write data handshake
- m_wdata  out  32  write data
- m_wstrb  out  4  always 4'hF
- m_bvalid / m_bready  in / out  1  write response handshake
- m_bresp  in  2  write response
- m_arvalid / m_arready  out / in  1  read address handshake
- m_araddr  out  13  read address
- m_rvalid / m_rready  in / out  1  read data handshake
- m_rdata  in  32  read data
- m_rresp  in  2  read response

Behaviour:
- Reset values: all outputs 0, except m_wstrb=4'hF. Reset is asynchronous; an in-flight transaction is abandoned. The shell resets the MAC in the same domain.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, FIN, ERR.
- Step list, with a 3-bit step counter:
  - S0: write 0x0000 = {mac[23:16], mac[31:24], mac[39:32], mac[47:40]}
  - S1: write 0x0004 = {16'h0, mac[7:0], mac[15:8]}
  - S2: write 0x07FC = 0x0000_0003 (program + busy)
  - S3: read 0x07FC, repeated until rdata[0]==0
  - S4: write 0x17FC = 0x0000_0008
  - S5: write 0x07F8 = 0x8000_0000
  - S4/S5 are skipped when ENABLE_IRQ=0.
- Start handling:
  - IDLE + start: latch mac_addr, clear done and error, set busy, go to WADDR (S0) on the next cycle.
  - start while busy is ignored.
- WADDR:
  - Assert awvalid and wvalid together.
  - Each valid drops on its own handshake (track aw_done/w_done); it is never withdrawn before ready.
  - Go to WRESP the cycle after both handshakes are done. Simultaneous or either-order ready is legal.
- WRESP:
  - bready=1; accept bvalid.
  - bresp≠0 → ERR.
  - Otherwise advance the step; go to RADDR for S3, FIN after the last step, else WADDR.
- RADDR: arvalid held until arready, then RDATA.
- RDATA:
  - rready=1; accept rvalid.
  - rresp≠0 → ERR.
  - rdata[0]==0 → next step.
  - rdata[0]==1 → increment poll_cnt. If poll_cnt reaches POLL_MAX → ERR, else RADDR, with no idle cycle between reads.
- poll_cnt width is $clog2(POLL_MAX+1), cleared on start.
- FIN: busy=0, done=1 (level), go to IDLE.
- ERR: busy=0, error=1 (level), go to IDLE. done stays 0.
- done and error hold until the next accepted start.
- At most one outstanding transaction at any time. Reads and writes never overlap.
- Minimum sequence length with zero-wait slaves and ENABLE_IRQ=1: 5 writes × 2 cycles + 1 read × 2 cycles + 1 cycle (start) + 1 cycle (FIN) = 14 cycles from start to done.

Decomposition:
- Package piton_aws_eth_pkg holds:
  - register offset localparams: ETH_TX_PING=13'h0000, ETH_TX_CTRL=13'h07FC, ETH_GIE=13'h07F8, ETH_RX_CTRL=13'h17FC
  - control bit constants
  - state enum typedef
- No sub-module; the step table is an internal case on the step counter.

Test Plan:
- Zero-wait slave, mac_addr=48'h00_0A_35_01_02_03, poll returns 0x0 on the first read:
  - writes 0x0000=0x01350A00, 0x0004=0x00000302, 0x07FC=0x3, 0x17FC=0x8, 0x07F8=0x80000000
  - done=1 14 cycles after start; error=0
- Slave asserts wready 3 cycles before awready, then vice versa:
  - exactly one AW and one W handshake per write
  - no valid drops before its ready; same data sequence as above
- Status read returns bit0=1 for 5 reads, then 0:
  - 6 reads of 0x07FC, then S4 proceeds; done=1
- POLL_MAX=4, status always 0x1:
  - exactly 4 reads, then error=1, done=0, busy=0, no further writes
- bresp=2'b10 on the S1 response:
  - error=1 with no S2 write issued
  - a later start reruns the full sequence from S0 and clears error
- rst asserted in WRESP of S2 with bvalid pending:
  - all outputs 0 in the same cycle (async)
  - after release, start reruns from S0; start pulses while busy have no effect

Source files
------------

// File: rtl/piton_aws_eth_init_seq_pkg.sv
// Shared constants for the Ethernet Lite MAC bring-up sequencer:
// register offsets, control bit values, FSM state type and the step table.
package piton_aws_eth_pkg;

   localparam logic [12:0] ETH_TX_PING    = 13'h0000;
   localparam logic [12:0] ETH_TX_PING_HI = 13'h0004;
   localparam logic [12:0] ETH_TX_CTRL    = 13'h07FC;
   localparam logic [12:0] ETH_GIE        = 13'h07F8;
   localparam logic [12:0] ETH_RX_CTRL    = 13'h17FC;

   // program-MAC + busy; the MAC clears bit 0 when programming finishes
   localparam logic [31:0] TX_CTRL_PROG = 32'h0000_0003;
   localparam int          TX_BUSY_BIT  = 0;
   localparam logic [31:0] RX_CTRL_IE   = 32'h0000_0008;
   localparam logic [31:0] GIE_EN       = 32'h8000_0000;

   localparam logic [1:0] AXI_OKAY = 2'b00;

   localparam logic [2:0] STEP_MAC_LO = 3'd0;
   localparam logic [2:0] STEP_MAC_HI = 3'd1;
   localparam logic [2:0] STEP_PROG   = 3'd2;
   localparam logic [2:0] STEP_POLL   = 3'd3;
   localparam logic [2:0] STEP_RX     = 3'd4;
   localparam logic [2:0] STEP_GIE    = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WRESP,
      RADDR,
      RDATA,
      FIN,
      ERR
   } state_t;

   function automatic logic [12:0] step_addr(input logic [2:0] s);
      case (s)
         STEP_MAC_LO: return ETH_TX_PING;
         STEP_MAC_HI: return ETH_TX_PING_HI;
         STEP_PROG:   return ETH_TX_CTRL;
         STEP_POLL:   return ETH_TX_CTRL;
         STEP_RX:     return ETH_RX_CTRL;
         STEP_GIE:    return ETH_GIE;
         default:     return ETH_TX_PING;
      endcase
   endfunction

   // The MAC takes the address byte-reversed: first wire octet in the LSB.
   function automatic logic [31:0] step_data(input logic [2:0]  s,
                                             input logic [47:0] mac);
      case (s)
         STEP_MAC_LO: return {mac[23:16], mac[31:24],
                              mac[39:32], mac[47:40]};
         STEP_MAC_HI: return {16'h0000, mac[7:0], mac[15:8]};
         STEP_PROG:   return TX_CTRL_PROG;
         STEP_RX:     return RX_CTRL_IE;
         STEP_GIE:    return GIE_EN;
         default:     return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/piton_aws_eth_init_seq_if.sv
// AXI4-Lite bundle between the init sequencer (master) and the MAC slave.
// Ports: AW/W/B write channels, AR/R read channels, 13-bit address.
interface piton_aws_eth_init_seq_if;

   logic        m_awvalid;
   logic        m_awready;
   logic [12:0] m_awaddr;
   logic        m_wvalid;
   logic        m_wready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_bvalid;
   logic        m_bready;
   logic [1:0]  m_bresp;
   logic        m_arvalid;
   logic        m_arready;
   logic [12:0] m_araddr;
   logic        m_rvalid;
   logic        m_rready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;

   modport master (
      output m_awvalid, m_awaddr,
      output m_wvalid, m_wdata, m_wstrb,
      output m_bready,
      output m_arvalid, m_araddr,
      output m_rready,
      input  m_awready, m_wready,
      input  m_bvalid, m_bresp,
      input  m_arready,
      input  m_rvalid, m_rdata, m_rresp
   );

   modport slave (
      input  m_awvalid, m_awaddr,
      input  m_wvalid, m_wdata, m_wstrb,
      input  m_bready,
      input  m_arvalid, m_araddr,
      input  m_rready,
      output m_awready, m_wready,
      output m_bvalid, m_bresp,
      output m_arready,
      output m_rvalid, m_rdata, m_rresp
   );

endinterface

// File: rtl/piton_aws_eth_init_seq.sv
// AXI4-Lite master that programs the Ethernet Lite MAC station address,
// polls for completion and optionally enables RX and global interrupts.
// Ports: clk, rst (async high), start pulse, mac_addr, busy/done/error
// status and the AXI-Lite master bundle axi.
module piton_aws_eth_init_seq
   import piton_aws_eth_pkg::*;
#(
   parameter int POLL_MAX   = 1024,
   parameter bit ENABLE_IRQ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [47:0] mac_addr,
   output logic        busy,
   output logic        done,
   output logic        error,
   piton_aws_eth_init_seq_if.master axi
);

   localparam int PW = $clog2(POLL_MAX + 1);
   localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

   state_t        state;
   logic [2:0]    step;
   logic [PW-1:0] poll_cnt;
   logic [47:0]   mac;
   logic          aw_done;
   logic          w_done;

   logic          awvalid;
   logic [12:0]   awaddr;
   logic          wvalid;
   logic [31:0]   wdata;
   logic          bready;
   logic          arvalid;
   logic [12:0]   araddr;
   logic          rready;

   logic          aw_fin;
   logic          w_fin;
   logic [2:0]    step_inc;
   logic [PW-1:0] poll_inc;
   logic          unused_rdata;

   assign axi.m_awvalid = awvalid;
   assign axi.m_awaddr  = awaddr;
   assign axi.m_wvalid  = wvalid;
   assign axi.m_wdata   = wdata;
   assign axi.m_wstrb   = 4'hF;
   assign axi.m_bready  = bready;
   assign axi.m_arvalid = arvalid;
   assign axi.m_araddr  = araddr;
   assign axi.m_rready  = rready;

   // each channel completes independently; either order is legal
   assign aw_fin   = aw_done | (awvalid & axi.m_awready);
   assign w_fin    = w_done | (wvalid & axi.m_wready);
   assign step_inc = step + 3'd1;
   assign poll_inc = poll_cnt + PW'(1);

   assign unused_rdata = ^axi.m_rdata[31:1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         step     <= STEP_MAC_LO;
         poll_cnt <= '0;
         mac      <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         awvalid  <= 1'b0;
         awaddr   <= '0;
         wvalid   <= 1'b0;
         wdata    <= '0;
         bready   <= 1'b0;
         arvalid  <= 1'b0;
         araddr   <= '0;
         rready   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  mac      <= mac_addr;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  busy     <= 1'b1;
                  step     <= STEP_MAC_LO;
                  poll_cnt <= '0;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
                  awvalid  <= 1'b1;
                  wvalid   <= 1'b1;
                  awaddr   <= step_addr(STEP_MAC_LO);
                  wdata    <= step_data(STEP_MAC_LO, mac_addr);
                  state    <= WADDR;
               end
            end

            WADDR: begin
               if (axi.m_awready) awvalid <= 1'b0;
               if (axi.m_wready) wvalid <= 1'b0;
               aw_done <= aw_fin;
               w_done  <= w_fin;
               if (aw_fin && w_fin) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  bready  <= 1'b1;
                  state   <= WRESP;
               end
            end

            WRESP: begin
               if (axi.m_bvalid) begin
                  bready <= 1'b0;
                  if (axi.m_bresp != AXI_OKAY) begin
                     state <= ERR;
                  end else if (step == STEP_GIE) begin
                     state <= FIN;
                  end else if (step == STEP_PROG) begin
                     step    <= STEP_POLL;
                     arvalid <= 1'b1;
                     araddr  <= step_addr(STEP_POLL);
                     state   <= RADDR;
                  end else begin
                     step    <= step_inc;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     awaddr  <= step_addr(step_inc);
                     wdata   <= step_data(step_inc, mac);
                     state   <= WADDR;
                  end
               end
            end

            RADDR: begin
               if (axi.m_arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RDATA;
               end
            end

            RDATA: begin
               if (axi.m_rvalid) begin
                  rready <= 1'b0;
                  if (axi.m_rresp != AXI_OKAY) begin
                     state <= ERR;
                  end else if (!axi.m_rdata[TX_BUSY_BIT]) begin
                     if (ENABLE_IRQ) begin
                        step    <= STEP_RX;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        awaddr  <= step_addr(STEP_RX);
                        wdata   <= step_data(STEP_RX, mac);
                        state   <= WADDR;
                     end else begin
                        state <= FIN;
                     end
                  end else begin
                     poll_cnt <= poll_inc;
                     if (poll_inc == POLL_LIM) begin
                        state <= ERR;
                     end else begin
                        // back-to-back re-read, no idle cycle
                        arvalid <= 1'b1;
                        state   <= RADDR;
                     end
                  end
               end
            end

            FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end

            ERR: begin
               busy  <= 1'b0;
               error <= 1'b1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
